// File: rtl/uart_rx_rtl.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first, one stop bit.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx_rtl #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             rx_busy,
    output logic             frame_err,
    output logic             parity_err
);
    localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int HALF        = BAUD_PERIOD / 2;
    localparam int CW          = $clog2(BAUD_PERIOD);
    localparam int BW          = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_FULL = CW'(BAUD_PERIOD - 1);
    localparam logic [CW-1:0] C_HALF = CW'(HALF - 1);
    localparam logic [BW-1:0] B_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_data_valid;
    logic             r_frame_err;
    logic             w_rx_s;
`ifdef UART_RX_PARITY_EN
    logic             r_parity_err;
    logic             r_par_bad;
`endif

    assign w_rx_s = r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
            r_par_bad    <= 1'b0;
`endif
        end else begin
            r_sync1      <= rx;
            r_sync2      <= r_sync1;
            r_rx_prev    <= w_rx_s;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    // Edge detection on rx_s keeps a held-low break from re-triggering.
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[WIDTH-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == C_FULL) begin
                        r_cnt     <= '0;
                        r_par_bad <= (^r_shift) ^ w_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch the next start edge.
                    if (r_cnt == C_FULL) begin
                        r_cnt       <= '0;
                        r_state     <= S_IDLE;
                        r_frame_err <= !w_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_bad;
                        if (w_rx_s && !r_par_bad) begin
                            r_data       <= r_shift;
                            r_data_valid <= 1'b1;
                        end
`else
                        if (w_rx_s) begin
                            r_data       <= r_shift;
                            r_data_valid <= 1'b1;
                        end
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign rx_busy    = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_rtl.sv
// Directed bench for uart_rx_rtl at default parameters (434 clocks per bit).
// Parity scenarios are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx_rtl;
    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int WIDTH     = 8;
    localparam int B         = CLK_FREQ / BAUD_RATE;
    localparam int HALF      = B / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = WIDTH + 2;
`else
    localparam int NBITS = WIDTH + 1;
`endif
    // start-edge drive to visible pulse: 3 cycles of sync + edge detect, then mid stop bit
    localparam int LAT = 3 + HALF + NBITS * B;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rx  = 1'b1;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic             rx_busy;
    logic             frame_err;
    logic             parity_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0, n_wide = 0, n_both = 0;
    int t_start = 0, t_valid = 0;
    logic pv = 1'b0, pf = 1'b0, pp = 1'b0;
    logic [WIDTH-1:0] got_q[$];
`ifdef UART_RX_PARITY_EN
    logic flip_par = 1'b0;
`endif

    uart_rx_rtl #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .WIDTH     (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_valid) begin
            n_valid++;
            got_q.push_back(data);
            t_valid = cyc;
        end
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if ((data_valid && pv) || (frame_err && pf) || (parity_err && pp)) n_wide++;
        if (data_valid && (frame_err || parity_err)) n_both++;
        pv = data_valid;
        pf = frame_err;
        pp = parity_err;
    end

    task automatic clear_mon();
        @(posedge clk);
        #1;
        n_valid = 0; n_ferr = 0; n_perr = 0; n_wide = 0; n_both = 0;
        got_q.delete();
        @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (B) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] d, input logic stop_bit);
        $display("frame %02h stop=%0b", d, stop_bit);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < WIDTH; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ flip_par);
`endif
        drive_bit(stop_bit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (data !== 8'h00)     begin bad++; $display("FAIL reset_data: got=%0h want=0", data); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%0b want=0", data_valid); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset_ferr: got=%0b want=0", frame_err); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr: got=%0b want=0", parity_err); end
        total++; if (rx_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got=%0b want=0", rx_busy); end
        rst = 1'b0;
        idle(20);
    endtask

    task automatic test_single();
        clear_mon();
        send_frame(8'h42, 1'b1);
        idle(B);
        total++; if (n_valid !== 1)    begin bad++; $display("FAIL single_valid_count: got=%0d want=1", n_valid); end
        total++; if (data !== 8'h42)   begin bad++; $display("FAIL single_data: got=%0h want=42", data); end
        total++; if (n_ferr !== 0)     begin bad++; $display("FAIL single_ferr: got=%0d want=0", n_ferr); end
        total++; if (n_wide !== 0)     begin bad++; $display("FAIL single_pulse_width: got=%0d wide pulses want=0", n_wide); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got=%0b want=0", rx_busy); end
        total++; if ((t_valid - t_start) < LAT - 2 || (t_valid - t_start) > LAT + 2) begin
            bad++; $display("FAIL single_latency: got=%0d want=%0d+-2", t_valid - t_start, LAT);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        send_frame(8'h42, 1'b1);
        send_frame(8'h6F, 1'b1);
        idle(B);
        total++; if (n_valid !== 2)     begin bad++; $display("FAIL b2b_valid_count: got=%0d want=2", n_valid); end
        total++; if (got_q[0] !== 8'h42) begin bad++; $display("FAIL b2b_first: got=%0h want=42", got_q[0]); end
        total++; if (got_q[1] !== 8'h6F) begin bad++; $display("FAIL b2b_second: got=%0h want=6f", got_q[1]); end
        total++; if (n_ferr !== 0)      begin bad++; $display("FAIL b2b_ferr: got=%0d want=0", n_ferr); end
        total++; if (n_wide !== 0)      begin bad++; $display("FAIL b2b_pulse_width: got=%0d want=0", n_wide); end
    endtask

    task automatic test_glitch();
        clear_mon();
        $display("glitch low 100 cycles");
        rx = 1'b0;
        repeat (50) @(negedge clk);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_during: got=%0b want=1", rx_busy); end
        repeat (50) @(negedge clk);
        idle(2 * B);
        total++; if (n_valid + n_ferr + n_perr !== 0) begin
            bad++; $display("FAIL glitch_pulses: got=%0d want=0", n_valid + n_ferr + n_perr);
        end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_after: got=%0b want=0", rx_busy); end
        total++; if (data !== 8'h6F)   begin bad++; $display("FAIL glitch_data_hold: got=%0h want=6f", data); end
    endtask

    task automatic test_frame_err_break();
        clear_mon();
        send_frame(8'h42, 1'b1);
        send_frame(8'hA5, 1'b0);
        // line stays low: a break spanning three more bit times
        repeat (3 * B) @(negedge clk);
        total++; if (n_ferr !== 1)      begin bad++; $display("FAIL ferr_count: got=%0d want=1", n_ferr); end
        total++; if (n_valid !== 1)     begin bad++; $display("FAIL ferr_valid_count: got=%0d want=1", n_valid); end
        total++; if (data !== 8'h42)    begin bad++; $display("FAIL ferr_data_hold: got=%0h want=42", data); end
        total++; if (n_both !== 0)      begin bad++; $display("FAIL ferr_overlap: got=%0d want=0", n_both); end
        total++; if (rx_busy !== 1'b0)  begin bad++; $display("FAIL break_busy: got=%0b want=0", rx_busy); end
        idle(2 * B);
        total++; if (n_valid + n_ferr !== 2) begin
            bad++; $display("FAIL break_no_restart: got=%0d pulses want=2", n_valid + n_ferr);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [WIDTH-1:0] d;
        clear_mon();
        d = 8'h55;
        $display("frame 55 interrupted by reset in bit 3");
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        rx = d[3];
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle(2 * B);
        total++; if (n_valid + n_ferr + n_perr !== 0) begin
            bad++; $display("FAIL rstmid_pulses: got=%0d want=0", n_valid + n_ferr + n_perr);
        end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got=%0b want=0", rx_busy); end
        total++; if (data !== 8'h00)   begin bad++; $display("FAIL rstmid_data_cleared: got=%0h want=0", data); end
        send_frame(8'h3C, 1'b1);
        idle(B);
        total++; if (n_valid !== 1)    begin bad++; $display("FAIL rstmid_valid_count: got=%0d want=1", n_valid); end
        total++; if (data !== 8'h3C)   begin bad++; $display("FAIL rstmid_data: got=%0h want=3c", data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [WIDTH-1:0] vals [6];
        vals = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'h7E, 8'h13};
        clear_mon();
        flip_par = 1'b0;
        send_frame(8'h42, 1'b1);
        idle(B);
        total++; if (n_valid !== 1)  begin bad++; $display("FAIL par_ok_valid: got=%0d want=1", n_valid); end
        total++; if (data !== 8'h42) begin bad++; $display("FAIL par_ok_data: got=%0h want=42", data); end
        total++; if (n_perr !== 0)   begin bad++; $display("FAIL par_ok_perr: got=%0d want=0", n_perr); end
        clear_mon();
        flip_par = 1'b1;
        send_frame(8'h99, 1'b1);
        idle(B);
        flip_par = 1'b0;
        total++; if (n_perr !== 1)   begin bad++; $display("FAIL par_bad_perr: got=%0d want=1", n_perr); end
        total++; if (n_valid !== 0)  begin bad++; $display("FAIL par_bad_valid: got=%0d want=0", n_valid); end
        total++; if (n_ferr !== 0)   begin bad++; $display("FAIL par_bad_ferr: got=%0d want=0", n_ferr); end
        total++; if (data !== 8'h42) begin bad++; $display("FAIL par_bad_data_hold: got=%0h want=42", data); end
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send_frame(vals[i], 1'b1);
            idle(B);
            total++; if (n_valid !== 1 || data !== vals[i]) begin
                bad++; $display("FAIL par_sweep_%0d: got=%0h valid=%0d want=%0h valid=1", i, data, n_valid, vals[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err_break();
        test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_rtl.md
UART_RX_RTL -- requirements
Module: uart_rx_rtl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-007 SHALL have port data, output, WIDTH, last correctly received word.
REQ-008 SHALL have port data_valid, output, 1, one-cycle pulse when data updates.
REQ-009 SHALL have port rx_busy, output, 1, high while a frame is in progress.
REQ-010 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port parity_err, output, 1, one-cycle pulse on a parity mismatch.

Function
REQ-012 SHALL define BAUD_PERIOD = CLK_FREQ/BAUD_RATE (integer division; 434 at defaults) and HALF = BAUD_PERIOD/2 (217).
REQ-013 SHALL pass rx through a 2-flop synchronizer; all decisions use the synchronized value rx_s.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 IDLE: on a falling edge of rx_s (previous 1, current 0) -> START, clk counter cleared.
REQ-016 START: at counter == HALF-1, rx_s==0 -> DATA with counter and bit counter cleared; rx_s==1 -> IDLE (glitch rejected, no output pulse).
REQ-017 DATA: at counter == BAUD_PERIOD-1, sample rx_s, shift in LSB-first, increment bit counter, clear clk counter; after WIDTH samples -> PARITY if enabled, else STOP.
REQ-018 STOP: at counter == BAUD_PERIOD-1, sample rx_s, return to IDLE next cycle; stop==1 -> data <= shift register and data_valid=1 for exactly one cycle; stop==0 -> frame_err=1 for one cycle, data unchanged, data_valid stays 0.
REQ-019 data_valid, frame_err and parity_err SHALL be registered and assert on the cycle after the stop-bit sample; they are never high together except frame_err with parity_err.
REQ-020 The sample points SHALL fall mid-bit: the first data sample is HALF+BAUD_PERIOD cycles after the detected start edge, plus 2 synchronizer cycles.
REQ-021 data SHALL hold its value between valid frames.
REQ-022 rx_busy SHALL be high in every state except IDLE.
REQ-023 A break (line held low past the stop bit) SHALL NOT start a new frame until rx_s returns high and falls again.
REQ-024 Back-to-back frames (new start bit directly after the stop bit) SHALL be received without loss, because the block returns to IDLE half a bit before the stop bit ends.

Reset
REQ-025 With rst high at a clock edge: state=IDLE; counters=0; shift register=0; data=0; data_valid=0; frame_err=0; parity_err=0; rx_busy=0; synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no output pulse; reception resumes on the next falling edge after rst is low.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: one even-parity bit follows the data bits; PARITY state samples it at counter == BAUD_PERIOD-1, then -> STOP.
REQ-028 If the XOR of the data bits and the parity bit is 1, parity_err SHALL pulse with the stop result; data SHALL NOT update and data_valid SHALL stay 0.
REQ-029 Macro UART_RX_PARITY_EN undefined: no PARITY state; frame is start + WIDTH + stop; parity_err tied 0.

Verification
REQ-030 Frame 0x42 (8N1, 434 cycles/bit) -> data=0x42, data_valid one cycle, frame_err=0, rx_busy low after.
REQ-031 Frames 0x42 then 0x6F back-to-back, no idle gap -> two data_valid pulses, data 0x42 then 0x6F.
REQ-032 rx low for 100 cycles then high -> no pulses, returns to IDLE, rx_busy low again.
REQ-033 Frame 0xA5 with stop bit forced 0 -> frame_err one cycle, data holds the previous value, no data_valid.
REQ-034 rst high during data bit 3 of 0x55, then a clean 0x3C -> no pulse for 0x55, data=0x3C with a single data_valid.
REQ-035 With UART_RX_PARITY_EN: 0x42 with parity 0 -> valid; with parity 1 -> parity_err pulse, no data_valid; a loopback from the team's UART transmitter checks data equality over 256 values.
